apb_regfile_slave: RTL and testbench
====================================

Name: apb_regfile_slave

Overview:
Parametrised APB completer with a bank of NUM_REGS read/write registers, programmable wait states, and address/alignment error signalling on pslverr. It is the next-generation replacement for the fixed five-register peripheral. It sits on the APB fabric behind the bridge/decoder, which drives pselx, and feeds control values to downstream logic through a flattened register bus.

Parameters:
DATA_W, 32, data bus width; multiple of 8, range 8..64.
ADDR_W, 32, paddr width.
NUM_REGS, 8, number of registers; range 1..256.
WAIT_STATES, 0, extra access-phase cycles inserted before pready; range 0..15.

Ports:
pclk  in  1  APB clock; all logic is on its rising edge.
preset  in  1  synchronous, active-high reset.
pselx  in  1  completer select.
penable  in  1  access-phase marker.
pwrite  in  1  1 = write, 0 = read.
paddr  in  ADDR_W  byte address.
pwdata  in  DATA_W  write data.
pready  out  1  transfer complete.
pslverr  out  1  transfer error; valid only while pready = 1.
prdata  out  DATA_W  read data; valid while pready = 1 on a read.
regs_o  out  NUM_REGS*DATA_W  flattened register contents; reg i occupies bits [i*DATA_W +: DATA_W].

Interface decided: one clock (pclk). preset is synchronous and active-high.

Behaviour:
- Reset (preset = 1 at a pclk edge): all registers = 0; state = IDLE; wait counter = 0; pready = 0; pslverr = 0; prdata = 0. Reset takes priority over any transfer in flight, and an interrupted write is not committed.
- Address decode: idx = paddr >> log2(DATA_W/8).
  - err_addr when idx >= NUM_REGS.
  - err_align when the low log2(DATA_W/8) bits of paddr are non-zero.
  - err = err_addr | err_align.
- FSM states:
  - IDLE: on an edge with pselx = 1 and penable = 0 (setup phase), go to ACCESS. At the same edge, latch idx, pwrite and err; load the wait counter with WAIT_STATES; for an error-free read, load prdata with reg[idx].
  - ACCESS: while pselx = 1, penable = 1 and the counter is non-zero, decrement the counter each edge. pready = 1 combinationally while state == ACCESS, counter == 0 and penable = 1. pready is decoded from registered state and is never asserted in IDLE.
  - Completion edge (pready = 1): for an error-free write, reg[idx] <= pwdata. Clear prdata to 0 and return to IDLE.
  - If pselx drops while in ACCESS, this is an abort: return to IDLE with no register update and prdata cleared.
- pslverr = pready & latched err.
  - An erroring write leaves every register unchanged.
  - An erroring read returns prdata = 0.
- Latency from setup-phase edge to pready: 1 + WAIT_STATES cycles, so with WAIT_STATES = 0 pready is high in the first access cycle.
- Back-to-back transfers: APB always has a setup phase between accesses, so every transfer passes through IDLE. No pipelining.
- pready is high for exactly one cycle per transfer.
- Register values and paddr/pwdata are sampled only at the edges stated above. Changes to paddr or pwdata during ACCESS are ignored; paddr is decoded from the setup-phase latch.
- A write to a register is visible on regs_o the cycle after the completion edge.

Optional Feature:
APB_PSTRB_EN
- Defined: adds input pstrb, width DATA_W/8. On an error-free write, only byte lanes with pstrb[b] = 1 are updated; the other lanes keep their value. pstrb = 0 completes normally with no change. pstrb is ignored on reads.
- Undefined: no pstrb port; every write updates the full word.

Test Plan:
- Reset: assert preset for 2 cycles, then idle 3 cycles -> pready = 0, pslverr = 0, prdata = 0, regs_o = 0.
- WAIT_STATES = 0: write 0xDEADBEEF to paddr 0x8, then read 0x8 -> pready high in the first access cycle of each transfer; read returns prdata = 0xDEADBEEF with pslverr = 0; regs_o reg2 = 0xDEADBEEF.
- WAIT_STATES = 3: read paddr 0x4 -> pready rises exactly 4 cycles after the setup edge and stays high for 1 cycle.
- Errors (NUM_REGS = 8): write 0x1234 to paddr 0x20, then write to paddr 0x6 -> each completes with pready = 1 and pslverr = 1; all regs unchanged. Read of 0x20 -> prdata = 0, pslverr = 1.
- Abort and reset mid-transfer (WAIT_STATES = 2):
  - Drop pselx during ACCESS of a write of 0xFF to 0x0 -> reg0 stays 0.
  - Repeat with preset asserted during ACCESS -> reg0 = 0, FSM in IDLE.
- APB_PSTRB_EN: reg1 = 0x11223344, write 0xAABBCCDD with pstrb = 4'b0101 -> reg1 = 0x11BB33DD.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// APB completer with NUM_REGS read/write registers, WAIT_STATES extra access cycles and
// pslverr on out-of-range or misaligned addresses. Define APB_PSTRB_EN for byte-lane write strobes.
module apb_regfile_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       pselx,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic [DATA_W-1:0]          pwdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_W/8-1:0]        pstrb,
`endif
  output logic                       pready,
  output logic                       pslverr,
  output logic [DATA_W-1:0]          prdata,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [3:0]        wait_cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic              write_r;
  logic              err_r;
  logic [DATA_W-1:0] prdata_r;

  logic [ADDR_W-1:0] idx_full_s;
  logic [IDX_W-1:0]  idx_s;
  logic              err_s;
  logic              setup_s;
  logic              abort_s;
  logic              pready_s;
  logic [BYTES-1:0]  strb_s;

  // Address decode of the live bus; only consumed at the setup-phase edge.
  always_comb begin
    idx_full_s = paddr >> OFF_W;
    idx_s      = idx_full_s[IDX_W-1:0];
    err_s      = (idx_full_s >= ADDR_W'(NUM_REGS)) || (|(paddr & ADDR_W'(BYTES - 1)));
    setup_s    = (state_r == ST_IDLE) && pselx && !penable;
    abort_s    = (state_r == ST_ACCESS) && !pselx;
`ifdef APB_PSTRB_EN
    strb_s     = pstrb;
`else
    strb_s     = {BYTES{1'b1}};
`endif
  end

  // FSM state register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; an abort (pselx dropped) wins over completion.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (setup_s) state_next_s = ST_ACCESS;
        else         state_next_s = ST_IDLE;
      end
      ST_ACCESS: begin
        if (abort_s || pready_s) state_next_s = ST_IDLE;
        else                     state_next_s = ST_ACCESS;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state plus penable.
  always_comb begin
    pready_s = (state_r == ST_ACCESS) && (wait_cnt_r == 4'd0) && penable;
    pready   = pready_s;
    pslverr  = pready_s & err_r;
    prdata   = prdata_r;
  end

  // Transfer latches, wait counter, read data and the register bank.
  always_ff @(posedge pclk) begin
    if (preset) begin
      wait_cnt_r <= 4'd0;
      idx_r      <= {IDX_W{1'b0}};
      write_r    <= 1'b0;
      err_r      <= 1'b0;
      prdata_r   <= {DATA_W{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (setup_s) begin
      idx_r      <= idx_s;
      write_r    <= pwrite;
      err_r      <= err_s;
      wait_cnt_r <= 4'(WAIT_STATES);
      if (!pwrite && !err_s) prdata_r <= regs_r[idx_s];
      else                   prdata_r <= {DATA_W{1'b0}};
    end else if (abort_s) begin
      prdata_r <= {DATA_W{1'b0}};
    end else if (pready_s) begin
      prdata_r <= {DATA_W{1'b0}};
      if (write_r && !err_r) begin
        for (int b = 0; b < BYTES; b++) begin
          if (strb_s[b]) regs_r[idx_r][b*8 +: 8] <= pwdata[b*8 +: 8];
        end
      end
    end else if ((state_r == ST_ACCESS) && penable && (wait_cnt_r != 4'd0)) begin
      wait_cnt_r <= wait_cnt_r - 4'd1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = regs_r[g];
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Self-checking bench for apb_regfile_slave: transaction-level register model, per-cycle
// compare of pready/pslverr/prdata/regs_o, directed corner cases and randomized transfers.
module tb_apb_regfile_slave;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 8;
  localparam int WS = 3;
  localparam int NB = DW / 8;

  logic          pclk = 1'b0;
  logic          preset, pselx, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
`ifdef APB_PSTRB_EN
  logic [NB-1:0] pstrb;
`endif
  logic             pready, pslverr;
  logic [DW-1:0]    prdata;
  logic [NR*DW-1:0] regs_o;

  apb_regfile_slave #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_STATES(WS)) dut (
    .pclk(pclk), .preset(preset), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .pready(pready), .pslverr(pslverr), .prdata(prdata), .regs_o(regs_o)
  );

  always #5 pclk = ~pclk;

  logic [DW-1:0]    model [NR];
  logic [NR*DW-1:0] exp_flat;
  logic             exp_pready, exp_pslverr, exp_rd, chk_en;
  logic [DW-1:0]    exp_prdata;
  int               n_cmp = 0, n_bad = 0;
  int               cyc = 0, setup_cyc = 0, last_lat = 0;
  logic [DW-1:0]    last_rdata;
  logic             last_err;

  task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (chk_en) begin
      for (int i = 0; i < NR; i++) exp_flat[i*DW +: DW] = model[i];
      chk("pready", pready, exp_pready);
      chk("pslverr", pslverr, exp_pslverr);
      chk("regs_o", regs_o, exp_flat);
      if (exp_rd) chk("prdata", prdata, exp_prdata);
      if (pready) begin
        last_rdata = prdata;
        last_err   = pslverr;
        last_lat   = cyc - setup_cyc + 1;
      end
    end
  end

  // One APB transfer; abort_at / rst_at select an access cycle to drop pselx or assert preset.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NB-1:0] s, input int abort_at, input int rst_at);
    logic err;
    int   idx;
    logic [NB-1:0] es;
    err = (a >= AW'(NR * NB)) || (a % NB != 0);
    idx = err ? 0 : int'(a / NB);
`ifdef APB_PSTRB_EN
    es = s;
    pstrb = s;
`else
    es = '1;
`endif
    pselx = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    exp_pready = 1'b0; exp_pslverr = 1'b0; exp_rd = 1'b0;
    last_rdata = '1; last_err = 1'b0;
    @(posedge pclk); #1;
    setup_cyc = cyc;
    paddr = $urandom;
    for (int j = 0; j <= WS; j++) begin
      if (j == abort_at) begin
        pselx = 1'b0; penable = 1'b0;
        exp_pready = 1'b0; exp_pslverr = 1'b0; exp_rd = 1'b0;
        @(posedge pclk); #1;
        break;
      end
      if (j == rst_at) begin
        preset = 1'b1; penable = 1'b1;
        exp_pready = 1'b0; exp_pslverr = 1'b0; exp_rd = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0; pselx = 1'b0; penable = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        break;
      end
      penable     = 1'b1;
      exp_pready  = (j == WS);
      exp_pslverr = (j == WS) && err;
      exp_rd      = (j == WS) && !wr;
      exp_prdata  = err ? '0 : model[idx];
      @(posedge pclk); #1;
      if (j == WS && wr && !err) begin
        for (int b = 0; b < NB; b++) if (es[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    pselx = 1'b0; penable = 1'b0;
    exp_pready = 1'b0; exp_pslverr = 1'b0; exp_rd = 1'b0;
    @(posedge pclk); #1;
  endtask

  initial begin
    logic [NR*DW-1:0] lit;
    logic [AW-1:0]    ra;
    int               sel, ab, rs;
    preset = 1'b1; pselx = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
`ifdef APB_PSTRB_EN
    pstrb = '0;
`endif
    chk_en = 1'b0; exp_pready = 1'b0; exp_pslverr = 1'b0; exp_rd = 1'b0; exp_prdata = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(posedge pclk); #1;
    chk_en = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_regs", regs_o, '0);
    chk("reset_prdata", prdata, '0);

    xfer(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, -1, -1);
    xfer(1'b0, 32'h8, 32'h0, 4'hF, -1, -1);
    chk("rd_deadbeef", last_rdata, 32'hDEADBEEF);
    chk("rd_latency", last_lat, 32'd4);
    chk("reg2", regs_o[64 +: 32], 32'hDEADBEEF);

    xfer(1'b1, 32'h20, 32'h1234, 4'hF, -1, -1);
    xfer(1'b1, 32'h6, 32'h5555, 4'hF, -1, -1);
    lit = '0;
    lit[64 +: 32] = 32'hDEADBEEF;
    chk("err_regs", regs_o, lit);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, -1, -1);
    chk("err_rd_data", last_rdata, 32'h0);
    chk("err_rd_slverr", last_err, 1'b1);

    xfer(1'b1, 32'h0, 32'hFF, 4'hF, 1, -1);
    chk("abort_reg0", regs_o[31:0], 32'h0);
    xfer(1'b0, 32'h8, 32'h0, 4'hF, -1, -1);
    chk("post_abort_lat", last_lat, 32'd4);

    xfer(1'b1, 32'h0, 32'hFF, 4'hF, -1, 1);
    chk("rst_mid_regs", regs_o, '0);
    xfer(1'b0, 32'h8, 32'h0, 4'hF, -1, -1);
    chk("post_rst_rd", last_rdata, 32'h0);
    chk("post_rst_lat", last_lat, 32'd4);

    xfer(1'b1, 32'h4, 32'h11223344, 4'hF, -1, -1);
    xfer(1'b1, 32'h4, 32'hAABBCCDD, 4'b0101, -1, -1);
`ifdef APB_PSTRB_EN
    chk("strb_reg1", regs_o[32 +: 32], 32'h11BB33DD);
    xfer(1'b1, 32'h4, 32'h99999999, 4'b0000, -1, -1);
    chk("strb_zero", regs_o[32 +: 32], 32'h11BB33DD);
`else
    chk("strb_reg1", regs_o[32 +: 32], 32'hAABBCCDD);
`endif

    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0)      ra = AW'($urandom_range(NR, 64) * NB);
      else if (sel == 1) ra = AW'($urandom_range(0, NR - 1) * NB + $urandom_range(1, NB - 1));
      else if (sel == 2) ra = $urandom;
      else               ra = AW'($urandom_range(0, NR - 1) * NB);
      ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, WS - 1) : -1;
      rs = ($urandom_range(0, 49) == 0) ? $urandom_range(0, WS - 1) : -1;
      xfer(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom), ab, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
